// File: rtl/papuf_eval_ctrl.sv
// papuf_eval_ctrl: drives one 16-bit pulse-arbiter PUF through repeated
// setup / fire / sample / recover evaluations of a single challenge. Each
// response bit is majority-voted over NUM_EVAL samples, and the block also
// reports which bits disagreed across those samples.
module papuf_eval_ctrl #(
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned PULSE_CYC   = 8,
    parameter int unsigned RECOVER_CYC = 8,
    parameter int unsigned NUM_EVAL    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_challenge,
    input  logic        abort,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] response,
    output logic [15:0] unstable,
    output logic [15:0] puf_challenge,
    output logic        puf_pulse,
    input  logic [15:0] puf_response
);

    localparam int unsigned CW   = $clog2(NUM_EVAL + 1);
    localparam int unsigned PMAX = (SETUP_CYC > PULSE_CYC)
                                 ? ((SETUP_CYC > RECOVER_CYC) ? SETUP_CYC : RECOVER_CYC)
                                 : ((PULSE_CYC > RECOVER_CYC) ? PULSE_CYC : RECOVER_CYC);
    localparam int unsigned PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYC - 1);
    localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYC - 1);
    localparam logic [PW-1:0] RECOVER_LAST = PW'(RECOVER_CYC - 1);
    localparam logic [CW-1:0] EVAL_TOTAL   = CW'(NUM_EVAL);
    localparam logic [CW-1:0] EVAL_HALF    = CW'(NUM_EVAL / 2);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, SAMPLE, RECOVER, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] phase_cnt;
    logic [CW-1:0] eval_cnt;
    logic [CW-1:0] ones [16];
    logic [15:0]   sync_q1;
    logic [15:0]   sync_q2;
    logic          accept;
    logic          sample_hit;
    logic          finish;
    logic          pulse_next;
    logic          valid_next;
    logic [15:0]   vote_resp;
    logic [15:0]   vote_unst;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; abort wins over every other input in every state.
    // NOTE: next_state gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!abort && req_valid) next_state = SETUP;
            SETUP:   if (abort) next_state = IDLE;
                     else if (phase_cnt == SETUP_LAST) next_state = FIRE;
            FIRE:    if (abort) next_state = IDLE;
                     else if (phase_cnt == PULSE_LAST) next_state = SAMPLE;
            SAMPLE:  next_state = abort ? IDLE : RECOVER;
            RECOVER: if (abort) next_state = IDLE;
                     else if (phase_cnt == RECOVER_LAST)
                         next_state = (eval_cnt < EVAL_TOTAL) ? FIRE : DONE;
            DONE:    if (abort || resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: handshake ready from the current state, registered
    // outputs and datapath strobes from the upcoming state.
    always_comb begin
        req_ready  = (state == IDLE);
        pulse_next = (next_state == FIRE) || (next_state == SAMPLE);
        valid_next = (next_state == DONE);
        accept     = (state == IDLE)    && (next_state == SETUP);
        sample_hit = (state == SAMPLE)  && (next_state == RECOVER);
        finish     = (state == RECOVER) && (next_state == DONE);
    end

    // Majority vote and disagreement flag per bit from the final counts.
    always_comb begin
        vote_resp = '0;
        vote_unst = '0;
        for (int i = 0; i < 16; i++) begin
            vote_resp[i] = (ones[i] > EVAL_HALF);
            vote_unst[i] = (ones[i] != '0) && (ones[i] != EVAL_TOTAL);
        end
    end

    // Phase counter restarts on every state change and only runs in timed states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    phase_cnt <= '0;
        else if (next_state != state)  phase_cnt <= '0;
        else if (state == SETUP || state == FIRE || state == RECOVER)
                                       phase_cnt <= phase_cnt + PW'(1);
    end

    // Two-flop synchronizer for the asynchronous array output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= puf_response;
            sync_q2 <= sync_q1;
        end
    end

    // Challenge latch plus per-bit ones counters and evaluation counter.
    // NOTE: the ones array is sixteen small flop counters, not a RAM, so it
    // takes the async reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puf_challenge <= '0;
            eval_cnt      <= '0;
            for (int i = 0; i < 16; i++) ones[i] <= '0;
        end else if (accept) begin
            puf_challenge <= req_challenge;
            eval_cnt      <= '0;
            for (int i = 0; i < 16; i++) ones[i] <= '0;
        end else if (sample_hit) begin
            eval_cnt <= eval_cnt + CW'(1);
            for (int i = 0; i < 16; i++) ones[i] <= ones[i] + CW'(sync_q2[i]);
        end
    end

    // Registered array pulse, response valid and the voted result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            puf_pulse  <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            unstable   <= '0;
        end else begin
            puf_pulse  <= pulse_next;
            resp_valid <= valid_next;
            if (finish) begin
                response <= vote_resp;
                unstable <= vote_unst;
            end
        end
    end

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// Bench for papuf_eval_ctrl: table vectors, random challenges with a
// majority-vote reference model, and hand-written abort/backpressure/reset
// sequences. A second instance exercises the single-evaluation configuration.
module tb_papuf_eval_ctrl;

    localparam int NE  = 5;
    localparam int LAT = 1 + 4 + NE * (8 + 1 + 8);

    typedef logic [NE-1:0][15:0] noise_t;
    typedef struct {
        logic [15:0] ch;
        noise_t      nz;
        logic [15:0] exp_r;
        logic [15:0] exp_u;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_valid, req_ready, abort, resp_valid, resp_ready, puf_pulse;
    logic [15:0] req_challenge, response, unstable, puf_challenge, puf_response;

    logic        s_req_valid, s_req_ready, s_abort, s_resp_valid, s_resp_ready, s_puf_pulse;
    logic [15:0] s_req_challenge, s_response, s_unstable, s_puf_challenge, s_puf_response;

    int total = 0;
    int bad   = 0;

    papuf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
        .abort(abort), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .response(response), .unstable(unstable),
        .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_response(puf_response)
    );

    papuf_eval_ctrl #(.SETUP_CYC(1), .PULSE_CYC(3), .RECOVER_CYC(1), .NUM_EVAL(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_challenge(s_req_challenge),
        .abort(s_abort), .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .response(s_response), .unstable(s_unstable),
        .puf_challenge(s_puf_challenge), .puf_pulse(s_puf_pulse), .puf_response(s_puf_response)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count ones per bit across evaluations, majority by 2*ones > NE.
    function automatic logic [31:0] vote_model(input logic [15:0] ch, input noise_t nz);
        logic [15:0] r;
        logic [15:0] u;
        logic [15:0] smp;
        int          cnt;
        r = '0;
        u = '0;
        for (int b = 0; b < 16; b++) begin
            cnt = 0;
            for (int k = 0; k < NE; k++) begin
                smp = ch ^ 16'hA5A5 ^ nz[k];
                if (smp[b]) cnt++;
            end
            r[b] = (2 * cnt > NE);
            u[b] = (cnt != 0) && (cnt != NE);
        end
        return {u, r};
    endfunction

    // Issue one request, play the array (per-evaluation noise), wait for resp_valid.
    task automatic run_req(input logic [15:0] ch, input noise_t nz,
                           output int lat, output int wins, output int badw);
        int   run_len;
        logic prev;
        @(negedge clk);
        req_challenge = ch;
        req_valid     = 1'b1;
        resp_ready    = 1'b0;
        puf_response  = ch ^ 16'hA5A5 ^ nz[0];
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1; wins = 0; badw = 0; run_len = 0; prev = 1'b0;
        while (lat < 400) begin
            @(negedge clk);
            if (puf_pulse) begin
                if (!prev) begin
                    if (wins < NE) puf_response = ch ^ 16'hA5A5 ^ nz[wins];
                    wins++;
                    run_len = 0;
                end
                run_len++;
            end else if (prev && run_len != 9) begin
                badw++;
            end
            prev = puf_pulse;
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic release_resp(input string name);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid_drop"}, resp_valid, 1'b0);
        check({name, "_ready_back"}, req_ready, 1'b1);
    endtask

    vec_t vecs[6];

    initial begin
        int          lat, wins, badw, cyc, run_len;
        logic        prev, saw_valid;
        logic [31:0] m;
        noise_t      nz;
        logic [15:0] ch;

        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; resp_ready = 1'b0;
        req_challenge = '0; puf_response = '0;
        s_req_valid = 1'b0; s_abort = 1'b0; s_resp_ready = 1'b0;
        s_req_challenge = '0; s_puf_response = '0;

        vecs[0] = '{ch: 16'h1234, nz: '0, exp_r: 16'hB791, exp_u: 16'h0000};
        vecs[1] = '{ch: 16'hA5A5, nz: '0, exp_r: 16'h0001, exp_u: 16'h0003};
        vecs[1].nz[0] = 16'h0001; vecs[1].nz[1] = 16'h0000; vecs[1].nz[2] = 16'h0001;
        vecs[1].nz[3] = 16'h0002; vecs[1].nz[4] = 16'h0001;
        vecs[2] = '{ch: 16'hFFFF, nz: '0, exp_r: 16'h5A5A, exp_u: 16'h0000};
        vecs[3] = '{ch: 16'h0000, nz: '1, exp_r: 16'h5A5A, exp_u: 16'h0000};
        vecs[4] = '{ch: 16'h0000, nz: '0, exp_r: 16'hA5A5, exp_u: 16'h00FF};
        vecs[4].nz[0] = 16'h00FF; vecs[4].nz[1] = 16'h00FF;
        vecs[5] = '{ch: 16'h0000, nz: '0, exp_r: 16'hA55A, exp_u: 16'h00FF};
        vecs[5].nz[0] = 16'h00FF; vecs[5].nz[1] = 16'h00FF; vecs[5].nz[2] = 16'h00FF;

        // Reset state.
        #2;
        check("rst_pulse", puf_pulse, 1'b0);
        check("rst_chal", puf_challenge, 16'h0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_resp", {unstable, response}, 32'h0);
        check("rst_ready", req_ready, 1'b1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Table vectors.
        for (int v = 0; v < 6; v++) begin
            run_req(vecs[v].ch, vecs[v].nz, lat, wins, badw);
            check($sformatf("vec%0d_latency", v), lat, LAT);
            check($sformatf("vec%0d_windows", v), wins, NE);
            check($sformatf("vec%0d_width", v), badw, 0);
            check($sformatf("vec%0d_resp", v), response, vecs[v].exp_r);
            check($sformatf("vec%0d_unst", v), unstable, vecs[v].exp_u);
            check($sformatf("vec%0d_chal", v), puf_challenge, vecs[v].ch);
            release_resp($sformatf("vec%0d", v));
        end

        // Random challenges and sparse noise against the vote model.
        for (int r = 0; r < 8; r++) begin
            ch = 16'($urandom);
            for (int k = 0; k < NE; k++) nz[k] = 16'($urandom & $urandom & $urandom);
            m = vote_model(ch, nz);
            run_req(ch, nz, lat, wins, badw);
            check($sformatf("rnd%0d_latency", r), lat, LAT);
            check($sformatf("rnd%0d_resp", r), response, m[15:0]);
            check($sformatf("rnd%0d_unst", r), unstable, m[31:16]);
            release_resp($sformatf("rnd%0d", r));
        end

        // Backpressure: hold 20 cycles, a stray request must be ignored.
        run_req(16'h1234, '0, lat, wins, badw);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1'b1);
            check("bp_resp", {unstable, response}, {16'h0000, 16'hB791});
            check("bp_ready", req_ready, 1'b0);
            check("bp_chal", puf_challenge, 16'h1234);
            req_valid     = (c == 10);
            req_challenge = 16'hBEEF;
        end
        req_valid = 1'b0;
        release_resp("bp");

        // Abort together with resp_ready while in DONE.
        run_req(16'h1234, '0, lat, wins, badw);
        @(negedge clk);
        abort = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        check("abort_done_valid", resp_valid, 1'b0);
        check("abort_done_ready", req_ready, 1'b1);

        // Abort in IDLE beats a simultaneous request.
        @(negedge clk);
        abort = 1'b1; req_valid = 1'b1; req_challenge = 16'h7777;
        @(posedge clk);
        #1 abort = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", req_ready, 1'b1);
        check("abort_idle_chal", puf_challenge, 16'h1234);
        repeat (6) @(negedge clk);
        check("abort_idle_pulse", puf_pulse, 1'b0);

        // Abort during evaluation 2 while in FIRE.
        @(negedge clk);
        req_challenge = 16'h0F0F; req_valid = 1'b1; puf_response = 16'h0F0F ^ 16'hA5A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wins = 0; prev = 1'b0; cyc = 0; run_len = 0;
        while (cyc < 300 && !(wins == 3 && run_len == 3)) begin
            @(negedge clk);
            cyc++;
            if (puf_pulse && !prev) begin wins++; run_len = 0; end
            if (puf_pulse) run_len++;
            prev = puf_pulse;
        end
        check("abort_fire_reached", wins, 3);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_fire_pulse", puf_pulse, 1'b0);
        check("abort_fire_ready", req_ready, 1'b1);
        check("abort_fire_valid", resp_valid, 1'b0);
        check("abort_fire_resp", {unstable, response}, {16'h0000, 16'hB791});
        saw_valid = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (resp_valid || puf_pulse) saw_valid = 1'b1;
        end
        check("abort_fire_quiet", saw_valid, 1'b0);
        run_req(16'h0F0F, '0, lat, wins, badw);
        check("post_abort_latency", lat, LAT);
        check("post_abort_resp", {unstable, response}, {16'h0000, 16'hAAAA});
        release_resp("post_abort");

        // Reset asserted during RECOVER of evaluation 0.
        @(negedge clk);
        req_challenge = 16'h3C3C; req_valid = 1'b1; puf_response = 16'h3C3C ^ 16'hA5A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wins = 0; prev = 1'b0; cyc = 0;
        while (cyc < 300 && !(wins == 1 && !puf_pulse)) begin
            @(negedge clk);
            cyc++;
            if (puf_pulse && !prev) wins++;
            prev = puf_pulse;
        end
        check("rst_mid_reached", wins, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", puf_pulse, 1'b0);
        check("rst_mid_chal", puf_challenge, 16'h0);
        check("rst_mid_valid", resp_valid, 1'b0);
        check("rst_mid_resp", {unstable, response}, 32'h0);
        check("rst_mid_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(16'hFFFF, '0, lat, wins, badw);
        check("post_rst_latency", lat, LAT);
        check("post_rst_resp", {unstable, response}, {16'h0000, 16'h5A5A});
        release_resp("post_rst");

        // Single-evaluation configuration: latency 7, never unstable.
        for (int r = 0; r < 4; r++) begin
            ch = 16'($urandom);
            @(negedge clk);
            s_puf_response  = 16'($urandom);
            s_req_challenge = ch;
            s_req_valid     = 1'b1;
            @(posedge clk);
            #1 s_req_valid = 1'b0;
            lat = 1;
            while (lat < 50) begin
                @(negedge clk);
                if (s_resp_valid) break;
                @(posedge clk);
                lat++;
            end
            check($sformatf("small%0d_latency", r), lat, 7);
            check($sformatf("small%0d_resp", r), s_response, s_puf_response);
            check($sformatf("small%0d_unst", r), s_unstable, 16'h0);
            check($sformatf("small%0d_chal", r), s_puf_challenge, ch);
            s_resp_ready = 1'b1;
            @(posedge clk);
            #1 s_resp_ready = 1'b0;
            @(negedge clk);
            check($sformatf("small%0d_drop", r), s_resp_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
